cr_frame_packer: RTL
====================

# cr_frame_packer

Downstream stage of the RAM0/RAM1 credit read path. Consumes the 16-bit output data stream, groups words into frames of a programmable length, appends one 16-bit checksum word per frame and marks it with tlast. The output is a registered AXI-Stream suitable for a DMA or a packet sink.

## Interface
Parameters:
- WIDTH, 16, data word width; checksum uses the same width.
- CNT_W, 16, width of the frame counter output.

Ports:
- clk  input  1  clock, single clock domain.
- reset_n  input  1  asynchronous reset, active low.
- stream_in  type_i_axis.slave  tdata[WIDTH]  input words; tlast is ignored.
- frame_len  input  4  payload words per frame; 0 means 16, 1..15 literal. Sampled on the first accepted word of each frame.
- frame_out  type_i_axis.master  tdata[WIDTH]  payload words followed by checksum; tlast = 1 on checksum only.
- frame_cnt  output  CNT_W  number of completed frames; wraps modulo 2^CNT_W.
- busy  output  1  1 = a frame is open: at least one word accepted, checksum not yet accepted downstream.

## Operation
- FSM states:
  - IDLE: no frame open.
  - DATA: payload words being collected.
  - CSUM: checksum word pending.
- IDLE -> DATA: on accepting the first word. Load len_q = (frame_len==0) ? 16 : frame_len, word_cnt = 1, sum = word.
- In DATA: each accepted word gives sum <= sum + word, modulo 2^WIDTH with carry discarded, and word_cnt <= word_cnt + 1.
- DATA -> CSUM: when the accepted word makes word_cnt == len_q.
  - If len_q == 1, IDLE goes straight to CSUM.
- CSUM: present sum with tlast = 1, and deassert stream_in.tready.
  - On checksum acceptance: frame_cnt += 1 and return to IDLE.
  - A word is not accepted in the same cycle; the next frame starts the following cycle at the earliest.
- Payload words are forwarded unchanged with tlast = 0, in order.
- Changes to frame_len during DATA/CSUM have no effect on the open frame.
- Output stage is a single register slice:
  - out_valid set on load, cleared on acceptance without reload.
  - stream_in.tready = (state != CSUM-pending-load) & (~out_valid | frame_out.tready).
  - Checksum loads into the slice only when the slice is empty or being drained that cycle.
- Reset during an open frame discards the frame entirely: no checksum is emitted and frame_cnt is unchanged, then cleared by reset.

## Timing
- Reset values:
  - frame_out.tvalid = 0, tdata = 0, tlast = 0.
  - stream_in.tready = 0 while reset_n = 0.
  - frame_cnt = 0, busy = 0, state = IDLE, sum = 0, word_cnt = 0.
- Latency: input acceptance at edge k -> word valid on frame_out from edge k (visible cycle k+1).
- Checksum appears on frame_out the cycle after the last payload word is accepted downstream, or is loaded the same edge that word drains.
- Throughput:
  - One word per cycle with frame_out.tready held 1.
  - Frame of N payload words occupies N+1 output cycles.
  - The input stalls exactly 1 cycle per frame.
- Handshake: once frame_out.tvalid is 1, tdata and tlast stay stable until tready. frame_out.tvalid never depends combinationally on frame_out.tready.
- Backpressure: with frame_out.tready = 0 and the slice full, stream_in.tready = 0 and no data is lost or duplicated.
- frame_cnt increments on the edge where the tlast word is accepted.
- busy:
  - Rises on the edge after the first accepted word.
  - Falls on the edge after checksum acceptance.

## Structure
- Package cr_frame_pkg:
  - typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CSUM} cr_frame_state_t.
  - LEN_ZERO_MEANS = 16.
- Sub-module cr_axis_reg_slice: one-entry register slice with valid/ready/data/last. It is the only output register; the FSM, counters and checksum stay in cr_frame_packer.

## Test plan
- frame_len = 4, words 0x0001, 0x0002, 0x0003, 0x0004, tready = 1 -> output 1, 2, 3, 4, then 0x000A with tlast = 1; frame_cnt = 1; input stalled 1 cycle.
- frame_len = 0, 16 words of 0xFFFF -> 16 payload words, then checksum 0xFFF0 (wrapped sum) with tlast; tlast appears only once.
- frame_len = 1, word 0x1234 -> 0x1234 (tlast = 0), then 0x1234 (tlast = 1); two back-to-back frames -> frame_cnt = 2.
- Random tready (50%) and random tvalid over 100 frames with frame_len = 3 -> output equals reference model; tdata/tlast stable while stalled; no drop or duplicate.
- frame_len changes from 4 to 2 after the first word -> current frame still 4 words; the next frame uses 2.
- reset_n pulsed low after 2 of 4 words -> tvalid = 0 immediately, frame_cnt = 0, no checksum emitted; the next frame is correct from scratch.

Source files
------------

// File: rtl/cr_frame_packer_pkg.sv
// Shared types and constants for the credit-path frame packer.
package cr_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CSUM
    } cr_frame_state_t;

    // A frame_len of 0 selects the longest frame.
    localparam int LEN_ZERO_MEANS = 16;

    // Wide enough to hold LEN_ZERO_MEANS.
    localparam int LEN_W = 5;

    // Map the 4-bit frame_len input to a payload word count.
    function automatic logic [LEN_W-1:0] decode_len(input logic [3:0] fl);
        if (fl == 4'd0) begin
            return LEN_W'(LEN_ZERO_MEANS);
        end
        return {1'b0, fl};
    endfunction

endpackage

// File: rtl/cr_frame_packer_if.sv
// AXI-Stream style handshake bundle used on both sides of the packer.
interface type_i_axis #(
    parameter int WIDTH = 16
);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;
    logic             tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/cr_frame_packer_reg_slice.sv
// One-entry register slice: the only output register of the packer.
// Accepts a new entry whenever it is empty or being drained this cycle.
module cr_axis_reg_slice #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             load;

    assign in_ready = ~valid_q | out_ready;
    assign load     = in_valid & in_ready;

    // Next-state: load on handshake, otherwise clear once drained, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            last_d  = in_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slice registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/cr_frame_packer.sv
// Groups input words into frames of frame_len words and appends a
// modulo-2^WIDTH checksum word marked with tlast.
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | no frame collecting; next accepted word opens one
// ST_DATA | payload words being collected
// ST_CSUM | checksum waiting to enter the output slice
module cr_frame_packer
    import cr_frame_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    type_i_axis.slave        stream_in,
    input  logic [3:0]       frame_len,
    type_i_axis.master       frame_out,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);

    cr_frame_state_t  state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic             slice_ready;
    logic             slice_valid;
    logic             slice_last;
    logic [WIDTH-1:0] slice_data;
    logic             slice_in_valid;
    logic [WIDTH-1:0] slice_in_data;
    logic             in_ready;
    logic             accept_in;
    logic             tlast_acc;
    logic [LEN_W-1:0] word_cnt_inc;
    logic             unused_tlast;

    // Input tlast carries no meaning here; framing is by count only.
    assign unused_tlast = stream_in.tlast;

    // Input is held off while reset is asserted and while the checksum waits.
    assign in_ready        = reset_n & (state_q != ST_CSUM) & slice_ready;
    assign stream_in.tready = in_ready;
    assign accept_in       = stream_in.tvalid & in_ready;

    assign slice_in_valid = (state_q == ST_CSUM) | accept_in;
    assign slice_in_data  = (state_q == ST_CSUM) ? sum_q : stream_in.tdata;
    assign tlast_acc      = slice_valid & slice_last & frame_out.tready;
    assign word_cnt_inc   = word_cnt_q + LEN_W'(1);

    cr_axis_reg_slice #(
        .WIDTH (WIDTH)
    ) u_slice (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (slice_in_valid),
        .in_data   (slice_in_data),
        .in_last   (state_q == ST_CSUM),
        .in_ready  (slice_ready),
        .out_valid (slice_valid),
        .out_data  (slice_data),
        .out_last  (slice_last),
        .out_ready (frame_out.tready)
    );

    assign frame_out.tvalid = slice_valid;
    assign frame_out.tdata  = slice_data;
    assign frame_out.tlast  = slice_last;

    // Next-state for the framing FSM, word counter, checksum and frame count.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        sum_d       = sum_q;
        frame_cnt_d = frame_cnt_q + CNT_W'(tlast_acc);
        case (state_q)
            ST_IDLE: begin
                if (accept_in) begin
                    len_d      = decode_len(frame_len);
                    word_cnt_d = LEN_W'(1);
                    sum_d      = stream_in.tdata;
                    state_d    = (len_d == LEN_W'(1)) ? ST_CSUM : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept_in) begin
                    sum_d      = sum_q + stream_in.tdata;
                    word_cnt_d = word_cnt_inc;
                    if (word_cnt_inc == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                // Checksum enters the slice this edge; the frame closes
                // downstream when the slice hands it off.
                if (slice_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            sum_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            sum_q       <= sum_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // A frame stays open until its checksum has left the output slice.
    assign busy      = (state_q != ST_IDLE) | (slice_valid & slice_last);
    assign frame_cnt = frame_cnt_q;

endmodule
